// File: rtl/h_sparse_encoder_pkg.sv
// Shared definitions for the sparse H feature format: default geometry,
// derived field widths and the packed word layouts that the SpMM/W*H
// stage reads back from the H_data and node_info BRAMs.
package h_sparse_encoder_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_NUM_FEATURE_IN = 21;
    localparam int DEF_TOTAL_NODES    = 200;
    localparam int DEF_H_DATA_DEPTH   = 2105;
    localparam int DEF_NUM_NODE_WIDTH = 5;

    localparam int COL_IDX_WIDTH    = $clog2(DEF_NUM_FEATURE_IN);
    localparam int ROW_LEN_WIDTH    = $clog2(DEF_NUM_FEATURE_IN);
    localparam int H_DATA_WIDTH     = DEF_DATA_WIDTH + COL_IDX_WIDTH;
    localparam int NODE_INFO_WIDTH  = ROW_LEN_WIDTH + DEF_NUM_NODE_WIDTH + 1;
    localparam int H_DATA_ADDR_W    = $clog2(DEF_H_DATA_DEPTH);
    localparam int NODE_INFO_ADDR_W = $clog2(DEF_TOTAL_NODES);

    // One stored non-zero: value in the MSBs, its dense column below it.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] value;
        logic [COL_IDX_WIDTH-1:0]  col_idx;
    } h_data_t;

    // One row descriptor.
    typedef struct packed {
        logic [ROW_LEN_WIDTH-1:0]      row_length;
        logic [DEF_NUM_NODE_WIDTH-1:0] num_of_nodes;
        logic                          source_node_flag;
    } node_info_t;

endpackage

// File: rtl/h_sparse_encoder_if.sv
// Feature-stream input and BRAM write-port bundle of the sparse encoder.
// master = feature loader side, slave = encoder side.
interface h_sparse_encoder_if
    import h_sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_FEATURE_IN = DEF_NUM_FEATURE_IN,
    parameter int TOTAL_NODES    = DEF_TOTAL_NODES,
    parameter int H_DATA_DEPTH   = DEF_H_DATA_DEPTH,
    parameter int NUM_NODE_WIDTH = DEF_NUM_NODE_WIDTH
);
    localparam int COL_W   = $clog2(NUM_FEATURE_IN);
    localparam int LEN_W   = $clog2(NUM_FEATURE_IN);
    localparam int HADDR_W = $clog2(H_DATA_DEPTH);
    localparam int NADDR_W = $clog2(TOTAL_NODES);

    logic                              i_start;
    logic                              i_feat_valid;
    logic [DATA_WIDTH-1:0]             i_feat;
    logic [NUM_NODE_WIDTH-1:0]         i_num_of_nodes;
    logic                              i_source_node_flag;
    logic                              o_feat_ready;
    logic                              o_h_data_we;
    logic [HADDR_W-1:0]                o_h_data_addr;
    logic [DATA_WIDTH+COL_W-1:0]       o_h_data_din;
    logic                              o_node_info_we;
    logic [NADDR_W-1:0]                o_node_info_addr;
    logic [LEN_W+NUM_NODE_WIDTH:0]     o_node_info_din;
    logic                              o_done;
    logic                              o_overflow;

    modport master (
        output i_start, i_feat_valid, i_feat, i_num_of_nodes, i_source_node_flag,
        input  o_feat_ready, o_h_data_we, o_h_data_addr, o_h_data_din,
               o_node_info_we, o_node_info_addr, o_node_info_din, o_done, o_overflow
    );

    modport slave (
        input  i_start, i_feat_valid, i_feat, i_num_of_nodes, i_source_node_flag,
        output o_feat_ready, o_h_data_we, o_h_data_addr, o_h_data_din,
               o_node_info_we, o_node_info_addr, o_node_info_din, o_done, o_overflow
    );

endinterface

// File: rtl/h_sparse_encoder.sv
// Dense row-major feature stream -> sparse H_data / node_info BRAM writes.
// Zeros are dropped, each non-zero becomes {value, col_idx}, and each row
// closes with one {row_length, num_of_nodes, source_node_flag} word.
// All writes are registered one cycle after the element handshake.
module h_sparse_encoder
    import h_sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_FEATURE_IN = DEF_NUM_FEATURE_IN,
    parameter int TOTAL_NODES    = DEF_TOTAL_NODES,
    parameter int H_DATA_DEPTH   = DEF_H_DATA_DEPTH,
    parameter int NUM_NODE_WIDTH = DEF_NUM_NODE_WIDTH
) (
    input logic               clk,
    input logic               rst,
    h_sparse_encoder_if.slave bus
);
    localparam int COL_W   = $clog2(NUM_FEATURE_IN);
    localparam int LEN_W   = $clog2(NUM_FEATURE_IN);
    localparam int HADDR_W = $clog2(H_DATA_DEPTH);
    localparam int NADDR_W = $clog2(TOTAL_NODES);
    // The pointer must be able to hold H_DATA_DEPTH itself to detect "full".
    localparam int PTR_W   = $clog2(H_DATA_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic [COL_W-1:0]          col_cnt;
    logic [NADDR_W-1:0]        row_idx;
    logic [PTR_W-1:0]          data_ptr;
    logic [LEN_W-1:0]          nz_cnt;
    logic [NUM_NODE_WIDTH-1:0] num_nodes_q;
    logic                      flag_q;

    logic                      hs, start_ok, is_nz, first_col, last_col, last_row, full;
    logic                      len_wrap;
    logic [LEN_W-1:0]          row_len;
    logic [NUM_NODE_WIDTH-1:0] num_nodes_row;
    logic                      flag_row;

    assign bus.o_feat_ready = (state == S_RUN);

    // Per-cycle decode of the handshake and the counter boundaries.
    always_comb begin
        hs        = (state == S_RUN) && bus.i_feat_valid;
        start_ok  = ((state == S_IDLE) || (state == S_DONE)) && bus.i_start;
        is_nz     = (bus.i_feat != '0);
        first_col = (col_cnt == '0);
        last_col  = (col_cnt == COL_W'(NUM_FEATURE_IN - 1));
        last_row  = (row_idx == NADDR_W'(TOTAL_NODES - 1));
        full      = (data_ptr == PTR_W'(H_DATA_DEPTH));
        // Row length including the element being accepted; wraps naturally.
        row_len   = nz_cnt + LEN_W'(is_nz);
        len_wrap  = is_nz && (nz_cnt == '1);
        // A one-column row must use the metadata presented with that element.
        num_nodes_row = first_col ? bus.i_num_of_nodes     : num_nodes_q;
        flag_row      = first_col ? bus.i_source_node_flag : flag_q;
    end

    // Frame sequencing: start a frame, run until the last row closes, wait.
    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.i_start) state_nxt = S_RUN;
            S_RUN:   if (hs && last_col && last_row) state_nxt = S_DONE;
            S_DONE:  if (bus.i_start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register in the design samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Counters, row metadata latch and registered BRAM write ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt              <= '0;
            row_idx              <= '0;
            data_ptr             <= '0;
            nz_cnt               <= '0;
            num_nodes_q          <= '0;
            flag_q               <= 1'b0;
            bus.o_h_data_we      <= 1'b0;
            bus.o_h_data_addr    <= '0;
            bus.o_h_data_din     <= '0;
            bus.o_node_info_we   <= 1'b0;
            bus.o_node_info_addr <= '0;
            bus.o_node_info_din  <= '0;
            bus.o_done           <= 1'b0;
            bus.o_overflow       <= 1'b0;
        end else begin
            bus.o_h_data_we    <= 1'b0;
            bus.o_node_info_we <= 1'b0;
            // Raised one cycle after the last node_info write, held until restart.
            bus.o_done         <= (state == S_DONE) && !bus.i_start;

            if (start_ok) begin
                col_cnt        <= '0;
                row_idx        <= '0;
                data_ptr       <= '0;
                nz_cnt         <= '0;
                bus.o_overflow <= 1'b0;
            end else if (hs) begin
                if (first_col) begin
                    num_nodes_q <= bus.i_num_of_nodes;
                    flag_q      <= bus.i_source_node_flag;
                end

                if (is_nz) begin
                    if (full) begin
                        // Capacity exhausted: drop the word but keep counting it.
                        bus.o_overflow <= 1'b1;
                    end else begin
                        bus.o_h_data_we   <= 1'b1;
                        bus.o_h_data_addr <= HADDR_W'(data_ptr);
                        bus.o_h_data_din  <= {bus.i_feat, col_cnt};
                        data_ptr          <= data_ptr + PTR_W'(1);
                    end
                end

                if (len_wrap) bus.o_overflow <= 1'b1;

                if (last_col) begin
                    bus.o_node_info_we   <= 1'b1;
                    bus.o_node_info_addr <= row_idx;
                    bus.o_node_info_din  <= {row_len, num_nodes_row, flag_row};
                    col_cnt              <= '0;
                    nz_cnt               <= '0;
                    row_idx              <= last_row ? '0 : row_idx + NADDR_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                    nz_cnt  <= row_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_h_sparse_encoder.sv
// Bench for h_sparse_encoder. Two encoders share one stimulus stream: one
// with ample H_data capacity and one with a 4-entry H_data to exercise the
// full condition. A behavioural model predicts every output each cycle;
// directed rows pin the model with hand-computed words.
`timescale 1ns/1ps
module tb_h_sparse_encoder;
    import h_sparse_encoder_pkg::*;

    localparam int NF      = DEF_NUM_FEATURE_IN;
    localparam int TN      = 3;
    localparam int DEPTH_A = DEF_H_DATA_DEPTH;
    localparam int DEPTH_B = 4;
    localparam int LEN_MOD = 1 << ROW_LEN_WIDTH;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_r = 1'b0;
    logic       valid_r = 1'b0;
    logic [7:0] feat_r  = '0;
    logic [4:0] nn_r    = '0;
    logic       fl_r    = 1'b0;

    h_sparse_encoder_if #(.TOTAL_NODES(TN), .H_DATA_DEPTH(DEPTH_A)) bus_a ();
    h_sparse_encoder_if #(.TOTAL_NODES(TN), .H_DATA_DEPTH(DEPTH_B)) bus_b ();

    assign bus_a.i_start            = start_r;
    assign bus_a.i_feat_valid       = valid_r;
    assign bus_a.i_feat             = feat_r;
    assign bus_a.i_num_of_nodes     = nn_r;
    assign bus_a.i_source_node_flag = fl_r;
    assign bus_b.i_start            = start_r;
    assign bus_b.i_feat_valid       = valid_r;
    assign bus_b.i_feat             = feat_r;
    assign bus_b.i_num_of_nodes     = nn_r;
    assign bus_b.i_source_node_flag = fl_r;

    h_sparse_encoder #(.TOTAL_NODES(TN), .H_DATA_DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    h_sparse_encoder #(.TOTAL_NODES(TN), .H_DATA_DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int depth [2] = '{DEPTH_A, DEPTH_B};
    int m_mode[2], m_col[2], m_row[2], m_ptr[2], m_nz[2], m_nn[2], m_fl[2];
    int e_hwe[2], e_haddr[2], e_hdin[2];
    int e_niwe[2], e_niaddr[2], e_nidin[2];
    int e_done[2], e_ovf[2], e_zero[2];

    task automatic model_step(input int k);
        int done_n;
        if (rst) begin
            m_mode[k] = M_IDLE; m_col[k] = 0; m_row[k] = 0; m_ptr[k] = 0; m_nz[k] = 0;
            e_hwe[k] = 0; e_niwe[k] = 0; e_done[k] = 0; e_ovf[k] = 0; e_zero[k] = 1;
            return;
        end
        e_zero[k] = 0;
        // done rises the cycle after the final row's descriptor is written
        done_n = e_done[k];
        if (e_niwe[k] != 0 && e_niaddr[k] == TN - 1) done_n = 1;
        e_hwe[k]  = 0;
        e_niwe[k] = 0;
        if (m_mode[k] != M_RUN && start_r) begin
            m_mode[k] = M_RUN; m_col[k] = 0; m_row[k] = 0; m_ptr[k] = 0; m_nz[k] = 0;
            e_ovf[k] = 0; done_n = 0;
        end else if (m_mode[k] == M_RUN && valid_r) begin
            if (m_col[k] == 0) begin
                m_nn[k] = int'(nn_r);
                m_fl[k] = int'(fl_r);
            end
            if (feat_r != 0) begin
                if (m_ptr[k] < depth[k]) begin
                    e_hwe[k]   = 1;
                    e_haddr[k] = m_ptr[k];
                    e_hdin[k]  = int'(feat_r) * (1 << COL_IDX_WIDTH) + m_col[k];
                    m_ptr[k]++;
                end else begin
                    e_ovf[k] = 1;
                end
                m_nz[k]++;
                if (m_nz[k] == LEN_MOD) e_ovf[k] = 1;
            end
            if (m_col[k] == NF - 1) begin
                e_niwe[k]   = 1;
                e_niaddr[k] = m_row[k];
                e_nidin[k]  = (m_nz[k] % LEN_MOD) * (1 << (DEF_NUM_NODE_WIDTH + 1))
                            + m_nn[k] * 2 + m_fl[k];
                m_col[k] = 0;
                m_nz[k]  = 0;
                m_row[k]++;
                if (m_row[k] == TN) m_mode[k] = M_DONE;
            end else begin
                m_col[k]++;
            end
        end
        e_done[k] = done_n;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic compare(input int k, input logic rdy, input logic hwe,
                           input logic [31:0] haddr, input logic [31:0] hdin,
                           input logic niwe, input logic [31:0] niaddr,
                           input logic [31:0] nidin, input logic done, input logic ovf);
        string p;
        p = (k == 0) ? "a" : "b";
        check({p, ".feat_ready"}, 32'(rdy), 32'(m_mode[k] == M_RUN));
        check({p, ".h_data_we"}, 32'(hwe), e_hwe[k]);
        if (e_hwe[k] != 0) begin
            check({p, ".h_data_addr"}, haddr, e_haddr[k]);
            check({p, ".h_data_din"}, hdin, e_hdin[k]);
        end
        check({p, ".node_info_we"}, 32'(niwe), e_niwe[k]);
        if (e_niwe[k] != 0) begin
            check({p, ".node_info_addr"}, niaddr, e_niaddr[k]);
            check({p, ".node_info_din"}, nidin, e_nidin[k]);
        end
        check({p, ".done"}, 32'(done), e_done[k]);
        check({p, ".overflow"}, 32'(ovf), e_ovf[k]);
        if (e_zero[k] != 0) begin
            check({p, ".rst_h_addr"}, haddr, 0);
            check({p, ".rst_h_din"}, hdin, 0);
            check({p, ".rst_ni_addr"}, niaddr, 0);
            check({p, ".rst_ni_din"}, nidin, 0);
        end
    endtask

    // Single compare process, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            compare(0, bus_a.o_feat_ready, bus_a.o_h_data_we, 32'(bus_a.o_h_data_addr),
                    32'(bus_a.o_h_data_din), bus_a.o_node_info_we, 32'(bus_a.o_node_info_addr),
                    32'(bus_a.o_node_info_din), bus_a.o_done, bus_a.o_overflow);
            compare(1, bus_b.o_feat_ready, bus_b.o_h_data_we, 32'(bus_b.o_h_data_addr),
                    32'(bus_b.o_h_data_din), bus_b.o_node_info_we, 32'(bus_b.o_node_info_addr),
                    32'(bus_b.o_node_info_din), bus_b.o_done, bus_b.o_overflow);
        end
    end

    // ---------------- write log for the directed literal checks ----------------
    logic [31:0] h_addr_q[$], h_din_q[$], ni_addr_q[$], ni_din_q[$];
    int          h_cyc_q[$], ni_cyc_q[$];
    int          b_h_cnt;
    logic [31:0] b_ni_din;
    int          done_rise_cyc;
    logic        done_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus_a.o_h_data_we === 1'b1) begin
                h_addr_q.push_back(32'(bus_a.o_h_data_addr));
                h_din_q.push_back(32'(bus_a.o_h_data_din));
                h_cyc_q.push_back(cyc);
            end
            if (bus_a.o_node_info_we === 1'b1) begin
                ni_addr_q.push_back(32'(bus_a.o_node_info_addr));
                ni_din_q.push_back(32'(bus_a.o_node_info_din));
                ni_cyc_q.push_back(cyc);
            end
            if (bus_b.o_h_data_we === 1'b1) b_h_cnt++;
            if (bus_b.o_node_info_we === 1'b1) b_ni_din = 32'(bus_b.o_node_info_din);
            if (bus_a.o_done === 1'b1 && !done_prev) done_rise_cyc = cyc;
            done_prev = (bus_a.o_done === 1'b1);
        end
    end

    task automatic clear_logs();
        h_addr_q.delete(); h_din_q.delete(); h_cyc_q.delete();
        ni_addr_q.delete(); ni_din_q.delete(); ni_cyc_q.delete();
        b_h_cnt = 0; b_ni_din = '0; done_rise_cyc = -1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] row_v [NF];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input logic [4:0] nn, input logic fl, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                valid_r = 1'b0;
                feat_r  = 8'($urandom);
                nn_r    = 5'($urandom);
                fl_r    = 1'($urandom);
                tick();
            end
        end
        valid_r = 1'b1;
        feat_r  = v;
        nn_r    = nn;
        fl_r    = fl;
        // i_start during RUN must be ignored
        start_r = gaps && ($urandom_range(0, 15) == 0);
        tick();
        valid_r = 1'b0;
        start_r = 1'b0;
    endtask

    task automatic send_row(input logic [4:0] nn, input logic fl, input bit gaps);
        for (int c = 0; c < NF; c++)
            send(row_v[c], (c == 0) ? nn : 5'($urandom), (c == 0) ? fl : 1'($urandom), gaps);
    endtask

    task automatic zero_row();
        for (int c = 0; c < NF; c++) row_v[c] = 8'h00;
    endtask

    task automatic rand_row();
        for (int c = 0; c < NF; c++)
            row_v[c] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        h_data_t    hd;
        node_info_t ni;
        int         sz;

        clear_logs();
        repeat (3) tick();
        check("reset.feat_ready", 32'(bus_a.o_feat_ready), 0);
        check("reset.done", 32'(bus_a.o_done), 0);
        check("reset.overflow_b", 32'(bus_b.o_overflow), 0);
        rst = 1'b0;
        tick();

        // Test 1: 5@0, 9@7, 0x80@20 in row 0
        start_frame();
        clear_logs();
        zero_row();
        row_v[0] = 8'h05; row_v[7] = 8'h09; row_v[20] = 8'h80;
        send_row(5'd6, 1'b1, 1'b0);
        tick(); tick();
        check("t1.h_count", h_addr_q.size(), 3);
        if (h_addr_q.size() == 3) begin
            hd = '{value: 8'h05, col_idx: 5'd0};
            check("t1.h0_addr", h_addr_q[0], 0); check("t1.h0_din", h_din_q[0], 32'(hd));
            hd = '{value: 8'h09, col_idx: 5'd7};
            check("t1.h1_addr", h_addr_q[1], 1); check("t1.h1_din", h_din_q[1], 32'(hd));
            hd = '{value: 8'h80, col_idx: 5'd20};
            check("t1.h2_addr", h_addr_q[2], 2); check("t1.h2_din", h_din_q[2], 32'(hd));
        end
        check("t1.ni_count", ni_addr_q.size(), 1);
        if (ni_addr_q.size() == 1 && h_cyc_q.size() == 3) begin
            ni = '{row_length: 5'd3, num_of_nodes: 5'd6, source_node_flag: 1'b1};
            check("t1.ni_addr", ni_addr_q[0], 0);
            check("t1.ni_din", ni_din_q[0], 32'(ni));
            check("t1.ni_same_cycle", ni_cyc_q[0], h_cyc_q[2]);
        end
        for (int r = 1; r < TN; r++) begin
            rand_row();
            send_row(5'($urandom), 1'($urandom), 1'b1);
        end
        repeat (3) tick();
        check("t1.frame_done", 32'(bus_a.o_done), 1);

        // Test 2: all-zero row then 1@3; pointers restart after i_start
        start_frame();
        clear_logs();
        zero_row();
        send_row(5'd3, 1'b0, 1'b1);
        tick(); tick();
        check("t2.row0_no_h", h_addr_q.size(), 0);
        ni = '{row_length: 5'd0, num_of_nodes: 5'd3, source_node_flag: 1'b0};
        check("t2.row0_ni_count", ni_addr_q.size(), 1);
        if (ni_addr_q.size() == 1) check("t2.row0_ni_din", ni_din_q[0], 32'(ni));
        row_v[3] = 8'h01;
        send_row(5'd9, 1'b1, 1'b1);
        tick(); tick();
        check("t2.row1_h_count", h_addr_q.size(), 1);
        if (h_addr_q.size() == 1) begin
            hd = '{value: 8'h01, col_idx: 5'd3};
            check("t2.row1_h_addr", h_addr_q[0], 0);
            check("t2.row1_h_din", h_din_q[0], 32'(hd));
        end
        check("t2.row1_ni_count", ni_addr_q.size(), 2);
        if (ni_addr_q.size() == 2) begin
            ni = '{row_length: 5'd1, num_of_nodes: 5'd9, source_node_flag: 1'b1};
            check("t2.row1_ni_addr", ni_addr_q[1], 1);
            check("t2.row1_ni_din", ni_din_q[1], 32'(ni));
        end
        rand_row();
        send_row(5'd2, 1'b0, 1'b1);
        repeat (3) tick();
        check("t2.done_level", 32'(bus_a.o_done), 1);
        check("t2.ready_low", 32'(bus_a.o_feat_ready), 0);
        check("t2.ni_count", ni_addr_q.size(), 3);
        if (ni_addr_q.size() == 3) check("t2.done_rise", done_rise_cyc, ni_cyc_q[2] + 1);
        // valid while DONE must not write anything
        sz = h_addr_q.size();
        valid_r = 1'b1; feat_r = 8'h55;
        repeat (4) tick();
        valid_r = 1'b0;
        tick();
        check("t2.no_write_in_done", h_addr_q.size(), sz);

        // Test 3: 6 non-zeros into the 4-deep H_data of dut_b
        start_frame();
        clear_logs();
        zero_row();
        for (int c = 0; c < 6; c++) row_v[c] = 8'(c + 1);
        send_row(5'd4, 1'b1, 1'b0);
        tick(); tick();
        check("t3.b_h_count", b_h_cnt, 4);
        check("t3.b_overflow", 32'(bus_b.o_overflow), 1);
        ni = '{row_length: 5'd6, num_of_nodes: 5'd4, source_node_flag: 1'b1};
        check("t3.b_ni_din", b_ni_din, 32'(ni));
        check("t3.a_no_overflow", 32'(bus_a.o_overflow), 0);
        for (int r = 1; r < TN; r++) begin
            rand_row();
            send_row(5'($urandom), 1'($urandom), 1'b1);
        end
        repeat (2) tick();

        // Random frames with gaps, ignored starts and stray valids
        for (int f = 0; f < 5; f++) begin
            repeat ($urandom_range(0, 3)) begin
                valid_r = 1'($urandom);
                feat_r  = 8'($urandom);
                tick();
            end
            valid_r = 1'b0;
            start_frame();
            for (int r = 0; r < TN; r++) begin
                rand_row();
                send_row(5'($urandom), 1'($urandom), 1'b1);
            end
            repeat ($urandom_range(1, 4)) tick();
        end

        // Test 4: reset at column 10 of row 1
        start_frame();
        rand_row();
        send_row(5'($urandom), 1'($urandom), 1'b1);
        for (int c = 0; c < 10; c++) send(8'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        valid_r = 1'b1; feat_r = 8'h77; rst = 1'b1;
        tick();
        check("t4.ready_low", 32'(bus_a.o_feat_ready), 0);
        check("t4.h_we_low", 32'(bus_a.o_h_data_we), 0);
        check("t4.ni_we_low", 32'(bus_a.o_node_info_we), 0);
        rst = 1'b0; valid_r = 1'b0;
        tick();
        clear_logs();
        start_frame();
        zero_row();
        row_v[0] = 8'h42;
        send_row(5'd1, 1'b1, 1'b0);
        tick(); tick();
        check("t4.h_count", h_addr_q.size(), 1);
        if (h_addr_q.size() == 1) begin
            hd = '{value: 8'h42, col_idx: 5'd0};
            check("t4.h_addr", h_addr_q[0], 0);
            check("t4.h_din", h_din_q[0], 32'(hd));
        end
        check("t4.ni_count", ni_addr_q.size(), 1);
        if (ni_addr_q.size() == 1) check("t4.ni_addr", ni_addr_q[0], 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/h_sparse_encoder.md
Name: h_sparse_encoder

Overview:
- Writer side of the sparse H feature format: converts a dense, row-major node-feature stream into the H_data and node_info BRAM contents that the SpMM/W·H stage reads.
- Zero features are dropped; each non-zero becomes one {value, col_idx} word; each row produces one node_info word {row_length, num_of_nodes, source_node_flag}.
- Sits between the host/DMA feature loader and the H_data / node_info BRAM write ports.

Parameters:
- DATA_WIDTH, 8, feature value width
- NUM_FEATURE_IN, 21, dense columns per row
- TOTAL_NODES, 200, rows per frame
- H_DATA_DEPTH, 2105, H_data BRAM depth
- NUM_NODE_WIDTH, 5, num_of_nodes field width
- Derived, not overridable: COL_IDX_WIDTH=$clog2(NUM_FEATURE_IN), ROW_LEN_WIDTH=$clog2(NUM_FEATURE_IN), H_DATA_ADDR_W=$clog2(H_DATA_DEPTH), NODE_INFO_ADDR_W=$clog2(TOTAL_NODES)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  begin new frame; honoured only in IDLE/DONE
- i_feat_valid  in  1  dense element valid
- i_feat  in  DATA_WIDTH  dense element value
- i_num_of_nodes  in  NUM_NODE_WIDTH  row metadata, sampled on column-0 handshake
- i_source_node_flag  in  1  row metadata, sampled on column-0 handshake
- o_feat_ready  out  1  element accepted when valid&ready
- o_h_data_we  out  1  H_data write enable
- o_h_data_addr  out  H_DATA_ADDR_W  H_data write address
- o_h_data_din  out  DATA_WIDTH+COL_IDX_WIDTH  {value, col_idx}, value in MSBs
- o_node_info_we  out  1  node_info write enable
- o_node_info_addr  out  NODE_INFO_ADDR_W  row index
- o_node_info_din  out  ROW_LEN_WIDTH+NUM_NODE_WIDTH+1  {row_length, num_of_nodes, source_node_flag}
- o_done  out  1  level; frame complete
- o_overflow  out  1  sticky; H_data capacity exceeded or row_length wrapped

Behaviour:
- Reset: state IDLE; all outputs 0; column, row, data-pointer and non-zero counters cleared.
- States:
  - IDLE: i_start -> RUN.
  - RUN: accepts elements.
  - DONE: i_start -> RUN.
- Entering RUN clears all counters and o_overflow.
- o_feat_ready = 1 only in RUN. While in RUN it never stalls.
- An element handshaked at column c in cycle t produces registered writes in cycle t+1 (latency 1):
  - Non-zero value: o_h_data_we=1, addr = data_ptr, din = {value, c[COL_IDX_WIDTH-1:0]}; then data_ptr++ and row nz_count++.
  - Zero value: no H_data write.
- Column 0: latch i_num_of_nodes and i_source_node_flag.
- Column NUM_FEATURE_IN-1, in the same cycle t+1 as any last H_data write:
  - o_node_info_we=1, addr = row index, row_length = nz_count including the last element.
  - Column counter wraps to 0, nz_count clears, row index increments.
- After the TOTAL_NODES-th row's node_info write: state DONE, o_done=1, o_feat_ready=0. o_done holds until i_start.
- Write enables are single-cycle pulses and are 0 when there is no handshake.
- Full condition: a non-zero arrives with data_ptr == H_DATA_DEPTH.
  - Suppress the H_data write, set o_overflow, keep counting row_length.
  - The node_info write still occurs.
- Row_length wrap: if a row's non-zero count exceeds 2^ROW_LEN_WIDTH-1 (possible only when NUM_FEATURE_IN is a power of 2), set o_overflow and write the truncated value.
- i_start while in RUN is ignored.
- rst mid-frame returns to IDLE next edge with all outputs 0. No partial write is completed.
- i_feat_valid outside RUN: ignored, no writes.

Decomposition:
- Shared params package:
  - new typedef h_data_t {value[DATA_WIDTH], col_idx[COL_IDX_WIDTH]}.
  - Reuse existing node_info_t and width constants (COL_IDX_WIDTH, ROW_LEN_WIDTH, NODE_INFO_WIDTH, H_DATA_ADDR_W, NODE_INFO_ADDR_W).
- State enum is local.
- No sub-module. Counters and the FSM fit in one module of about 180 lines.

Test Plan:
- Reset, then i_start, then one row with non-zeros 5@col0, 9@col7, 0x80@col20, all else 0.
  - H_data writes at addr 0/1/2: {0x05,5'd0}, {0x09,5'd7}, {0x80,5'd20}.
  - node_info addr 0: {row_length=3, num_of_nodes, flag}, asserted in the same cycle as the last H_data write.
- All-zero row followed by a row with non-zero 1@col3.
  - node_info row0 row_length=0, no H_data writes for row0.
  - Row1: H_data addr 0 = {0x01,3}, node_info addr 1 row_length=1.
- TOTAL_NODES=3, random valid gaps.
  - o_done rises the cycle after the row-2 node_info write; o_feat_ready=0 afterwards.
  - A further i_start clears pointers; the next write is at addr 0.
- H_DATA_DEPTH=4, a row of 6 non-zeros.
  - Exactly 4 H_data writes, o_overflow=1, node_info row_length=6.
- Assert rst at column 10 of row 1.
  - Next cycle all outputs 0, state IDLE, o_feat_ready=0.
  - After i_start, the first write goes to H_data addr 0 and node_info addr 0.
